// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus: EX redirect, instruction-memory request/response and
// the ID-side valid/stall handshake.
interface fetch_prefetch_queue_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned INST_W = 16,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              branch_i;
  logic [ADDR_W-1:0] baddr_i;
  logic              req_o;
  logic [ADDR_W-1:0] addr_o;
  logic [INST_W-1:0] inst_i;
  logic              v_o;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] origaddr_o;
  logic              stall_i;
  logic [CntW-1:0]   count_o;

  modport slave (
    input  branch_i, baddr_i, inst_i, stall_i,
    output req_o, addr_o, v_o, inst_o, origaddr_o, count_o
  );

  modport master (
    output branch_i, baddr_i, inst_i, stall_i,
    input  req_o, addr_o, v_o, inst_o, origaddr_o, count_o
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues PC fetches to a 1-cycle memory, buffers
// returned words with their addresses, and flushes everything on a redirect.
module fetch_prefetch_queue #(
  parameter int unsigned      ADDR_W     = 16,
  parameter int unsigned      INST_W     = 16,
  parameter int unsigned      DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input logic                   clk,
  input logic                   rst,
  fetch_prefetch_queue_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              inflight_q, inflight_d;
  logic              run_q;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_d [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_d [DEPTH];

  logic            issue;
  logic            push;
  logic            pop;
  logic [OccW-1:0] occupancy;

  always_comb begin
    pop  = (count_q != '0) && !bus.stall_i;
    push = inflight_q && !bus.branch_i;
    // Slots committed after this edge: the in-flight word will land next cycle.
    occupancy = OccW'(count_q) + OccW'(inflight_q) - OccW'(pop);
    // run_q holds off the first fetch until the first edge after reset release.
    issue = run_q && !bus.branch_i && (occupancy < OccW'(DEPTH));
  end

  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inst_mem_d = inst_mem_q;
    addr_mem_d = addr_mem_q;

    if (bus.branch_i) begin
      pc_d     = bus.baddr_i;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        pc_d  = pc_q + ADDR_W'(1);
        tag_d = pc_q;
      end
      if (push) begin
        inst_mem_d[wr_ptr_q] = bus.inst_i;
        addr_mem_d[wr_ptr_q] = tag_q;
      end
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      count_d  = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_ADDR;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      run_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inst_mem_q <= '{default: '0};
      addr_mem_q <= '{default: '0};
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      run_q      <= 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inst_mem_q <= inst_mem_d;
      addr_mem_q <= addr_mem_d;
    end
  end

  assign bus.req_o      = issue;
  assign bus.addr_o     = pc_q;
  assign bus.v_o        = (count_q != '0);
  assign bus.inst_o     = inst_mem_q[rd_ptr_q];
  assign bus.origaddr_o = addr_mem_q[rd_ptr_q];
  assign bus.count_o    = count_q;

endmodule
